reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth is 2**ADDR_W registers.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Ports rd_addr1, rd_addr2  input  ADDR_W  read-port addresses.
REQ-006 Ports rd_data1, rd_data2  output  DATA_W  read data, combinational from the read addresses.
REQ-007 Ports wr_en1, wr_en2  input  1  write enables: port 1 is the ALU writeback, port 2 is the load writeback.
REQ-008 Ports wr_addr1, wr_addr2  input  ADDR_W  write addresses.
REQ-009 Ports wr_data1, wr_data2  input  DATA_W  write data.
REQ-010 Port iss_valid  input  1  an instruction issues a pending write.
REQ-011 Port iss_addr  input  ADDR_W  destination of the issuing instruction.
REQ-012 Ports busy1, busy2  output  1  scoreboard busy bit of rd_addr1 / rd_addr2, combinational.
REQ-013 Port busy_cnt  output  ADDR_W+1  count of registers currently busy.

Function
REQ-014 Writes SHALL commit on the rising clk edge when the corresponding wr_enN is 1; with wr_enN 0 the port SHALL have no effect.
REQ-015 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded, and issues to address 0 SHALL be ignored.
REQ-016 If both ports write the same nonzero address in one cycle, port 2's data SHALL be stored.
REQ-017 A read with no same-cycle write to its address SHALL return the stored value with zero-cycle latency.
REQ-018 iss_valid SHALL set the busy bit of iss_addr at the next edge.
REQ-019 A write commit on either port SHALL clear the busy bit of its address at the next edge.
REQ-020 If an issue and a write to the same address occur in the same cycle, the busy bit SHALL end set; the issue takes priority.
REQ-021 busy_cnt SHALL equal the popcount of the busy bits after each edge.
REQ-022 busy_cnt SHALL saturate at 2**ADDR_W-1, because register 0 is never busy.
REQ-023 A write to a non-busy register SHALL still be performed; the busy bit SHALL remain 0.

Reset
REQ-024 While rst_n is 0, all registers SHALL be 0, all busy bits SHALL be 0, and busy_cnt SHALL be 0, asynchronously and regardless of clk.
REQ-025 Writes and issues presented while rst_n is 0 SHALL be discarded.
REQ-026 Operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-027 The macro REG_FILE_BYPASS_EN SHALL control read-during-write forwarding.
REQ-028 With REG_FILE_BYPASS_EN defined, a read of an address being written in the same cycle SHALL return the write data (port 2 if both ports write it) and busyN SHALL read 0.
REQ-029 Without REG_FILE_BYPASS_EN, that read SHALL return the old stored value and busyN SHALL reflect the pre-edge state.

Structure
REQ-030 Package reg_file_pkg SHALL hold the DATA_W and ADDR_W defaults, the REG_ZERO address constant, and the write-port priority constant.
REQ-031 The scoreboard (busy bits plus busy_cnt) SHALL be a sub-module named reg_scoreboard; the storage array and bypass logic SHALL stay in reg_file_sb.

Verification
REQ-032 Reset scenario: assert rst_n=0 mid-run after writing 0xFFFFFFFF to r10 -> rd_data of r10 reads 0 immediately, and busy_cnt reads 0.
REQ-033 Single write: wr_en1=1, r10=0xFFFFFFFF, wr_en2=0 with r11=0 -> after the edge r10 reads 0xFFFFFFFF and r11 is unchanged.
REQ-034 Same-address conflict: wr1 r12=0x1, wr2 r12=0x2 -> r12 reads 0x2; a write to r0 of 0x5 -> r0 reads 0.
REQ-035 Scoreboard: issue r13, then r14 -> busy_cnt is 2; write r13 with a simultaneous issue of r13 -> busy1 for r13 stays 1; write r14 -> busy_cnt is 1.
REQ-036 Bypass: read r15 while writing r15=0x64 -> rd_data reads 0x64 with the macro defined, and the old value without it.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file with scoreboard.
// Optional build macro: REG_FILE_BYPASS_EN (read-during-write forwarding).
package reg_file_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   // Hard-wired zero register: never written, never busy
   localparam int REG_ZERO = 0;

   // Write port whose data wins when both ports write the same register
   localparam int WR_PRIO_PORT = 2;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding issued write.
// Optional build macro: REG_FILE_BYPASS_EN (busy reads 0 for a register being written).
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic              wr_en2,
   input  logic [ADDR_W-1:0] wr_addr2,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH - 1);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;
   logic [ADDR_W:0]  cnt_next;

   // Next busy vector: commits clear first, then an issue sets, so issue wins a tie
   always_comb begin
      busy_next = busy;
      cnt_next  = '0;
      if (wr_en1) busy_next[wr_addr1] = 1'b0;
      if (wr_en2) busy_next[wr_addr2] = 1'b0;
      if (iss_valid) busy_next[iss_addr] = 1'b1;
      busy_next[REG_ZERO] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_next = cnt_next + (ADDR_W+1)'(busy_next[i]);
      end
      if (cnt_next > CNT_MAX) cnt_next = CNT_MAX;
   end

   // Busy bits and their registered population count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

`ifdef REG_FILE_BYPASS_EN
   // A register being written this cycle is reported as already free
   always_comb begin
      busy1 = busy[rd_addr1] & ~((wr_en1 && wr_addr1 == rd_addr1) || (wr_en2 && wr_addr2 == rd_addr1));
      busy2 = busy[rd_addr2] & ~((wr_en1 && wr_addr1 == rd_addr2) || (wr_en2 && wr_addr2 == rd_addr2));
   end
`else
   // Busy outputs show the state held before the coming edge
   always_comb begin
      busy1 = busy[rd_addr1];
      busy2 = busy[rd_addr2];
   end
`endif

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, two-write register file with an issue scoreboard; r0 reads as zero.
// Optional build macro: REG_FILE_BYPASS_EN (forward same-cycle write data to reads).
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en1,
   input  logic              wr_en2,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [ADDR_W-1:0] wr_addr2,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic [DATA_W-1:0] wr_data2,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs [DEPTH];
   logic              commit1;
   logic              commit2;
   logic              both_same;
   logic [DATA_W-1:0] tie_data;

   // Writes to r0 are dropped before they reach storage or the scoreboard
   always_comb begin
      commit1   = wr_en1 && (wr_addr1 != ZERO_ADDR);
      commit2   = wr_en2 && (wr_addr2 != ZERO_ADDR);
      both_same = commit1 && commit2 && (wr_addr1 == wr_addr2);
      tie_data  = (WR_PRIO_PORT == 2) ? wr_data2 : wr_data1;
   end

   // Storage array; a same-register tie takes the priority port's data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (both_same && wr_addr1 == ADDR_W'(i)) regs[i] <= tie_data;
            else if (commit2 && wr_addr2 == ADDR_W'(i)) regs[i] <= wr_data2;
            else if (commit1 && wr_addr1 == ADDR_W'(i)) regs[i] <= wr_data1;
         end
      end
   end

   // Combinational read ports, optionally forwarding this cycle's write data
   always_comb begin
      rd_data1 = (rd_addr1 == ZERO_ADDR) ? '0 : regs[rd_addr1];
      rd_data2 = (rd_addr2 == ZERO_ADDR) ? '0 : regs[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
      if (rst_n) begin
         if (both_same && wr_addr1 == rd_addr1) rd_data1 = tie_data;
         else if (commit2 && wr_addr2 == rd_addr1) rd_data1 = wr_data2;
         else if (commit1 && wr_addr1 == rd_addr1) rd_data1 = wr_data1;
         if (both_same && wr_addr1 == rd_addr2) rd_data2 = tie_data;
         else if (commit2 && wr_addr2 == rd_addr2) rd_data2 = wr_data2;
         else if (commit1 && wr_addr1 == rd_addr2) rd_data2 = wr_data1;
      end
`endif
   end

   reg_scoreboard #(
      .ADDR_W(ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .iss_valid(iss_valid),
      .iss_addr (iss_addr),
      .wr_en1   (commit1),
      .wr_addr1 (wr_addr1),
      .wr_en2   (commit2),
      .wr_addr2 (wr_addr2),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .busy1    (busy1),
      .busy2    (busy2),
      .busy_cnt (busy_cnt)
   );

endmodule
